bbc_keyboard_matrix: RTL



---
 rtl/bbc_keyboard_matrix_pkg.sv | 35 +++
 rtl/bbc_kb_col_counter.sv | 46 ++++
 rtl/bbc_keyboard_matrix.sv | 107 ++++++++++
 3 files changed

// File: rtl/bbc_keyboard_matrix_pkg.sv
// Shared constants, key-code layout and named keys for the BBC Micro keyboard matrix.
// Optional row-0 DIP link emulation is selected with KB_DIPSWITCH_EN.
package bbc_keyboard_matrix_pkg;

  localparam int KB_COLS = 10;
  localparam int KB_ROWS = 8;

  localparam int KC_COL_LSB = 0;
  localparam int KC_COL_W   = 4;
  localparam int KC_ROW_LSB = 4;
  localparam int KC_ROW_W   = 3;

  typedef struct packed {
    logic [KC_ROW_W-1:0] row;
    logic [KC_COL_W-1:0] col;
  } key_code_t;

  localparam logic [6:0] KEY_SHIFT  = 7'h00;
  localparam logic [6:0] KEY_CTRL   = 7'h01;
  localparam logic [6:0] KEY_SPACE  = 7'h62;
  localparam logic [6:0] KEY_RETURN = 7'h49;

  function automatic logic kb_col_present(input logic [3:0] col);
    return col < 4'(KB_COLS);
  endfunction

  // Row 0, columns 2..9 are the startup links on real hardware.
  function automatic logic kb_is_link(
    input logic [2:0] row,
    input logic [3:0] col
  );
    return (row == 3'd0) && (col >= 4'd2) && (col <= 4'd9);
  endfunction

endpackage

// File: rtl/bbc_kb_col_counter.sv
// Column counter with scan prescaler: loads from port A in manual mode,
// free-runs at clk/SCAN_DIV in autoscan mode (LS163 equivalent).
import bbc_keyboard_matrix_pkg::*;

module bbc_kb_col_counter #(
  parameter int unsigned SCAN_DIV = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_en,
  input  logic [3:0] load_val,
  output logic [3:0] cnt
);

  localparam logic [7:0] PRE_TC = 8'(SCAN_DIV - 1);

  logic [7:0] pre_q, pre_d;
  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    pre_d = pre_q;
    cnt_d = cnt_q;
    if (load_en) begin
      pre_d = '0;
      cnt_d = load_val;
    end else if (pre_q == PRE_TC) begin
      pre_d = '0;
      cnt_d = cnt_q + 4'd1;
    end else begin
      pre_d = pre_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
      cnt_q <= '0;
    end else begin
      pre_q <= pre_d;
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/bbc_keyboard_matrix.sv
// BBC Micro keyboard: 10x8 key state, column scan, PA7 mux and CA2 interrupt.
// Define KB_DIPSWITCH_EN to return DIP_LINKS on row 0, columns 2..9.
import bbc_keyboard_matrix_pkg::*;

module bbc_keyboard_matrix #(
  parameter int unsigned SCAN_DIV  = 2,
  parameter logic [7:0]  DIP_LINKS = 8'h00
) (
  input  logic       clk2MHz,
  input  logic       nRESET,
  input  logic       nKB_EN,
  input  logic [6:0] PA_OUT,
  input  logic       key_valid,
  input  logic       key_make,
  input  logic [6:0] key_code,
  input  logic       kb_clear,
  output logic       PA7,
  output logic       CA2,
  output logic [3:0] col_cnt
);

  logic [KB_ROWS-1:0][KB_COLS-1:0] key_q, key_d;
  logic                            ca2_q, ca2_d;
  logic [KB_ROWS-1:0]              cur_col;
  logic [2:0]                      pa_row;
  logic                            ev_ok;
  key_code_t                       ev;

  bbc_kb_col_counter #(
    .SCAN_DIV (SCAN_DIV)
  ) u_col_cnt (
    .clk      (clk2MHz),
    .rst_n    (nRESET),
    .load_en  (!nKB_EN),
    .load_val (PA_OUT[3:0]),
    .cnt      (col_cnt)
  );

  assign ev = key_code_t'(key_code);

`ifdef KB_DIPSWITCH_EN
  assign ev_ok = kb_col_present(ev.col) && !kb_is_link(ev.row, ev.col);
`else
  assign ev_ok = kb_col_present(ev.col);
`endif

  always_comb begin
    key_d = key_q;
    if (kb_clear) begin
      key_d = '0;
    end else if (key_valid && ev_ok) begin
      for (int c = 0; c < KB_COLS; c++) begin
        if (ev.col == 4'(c)) begin
          key_d[ev.row][c] = key_make;
        end
      end
    end
  end

  // Columns 10..15 match nothing and read back as all zero.
  always_comb begin
    cur_col = '0;
    for (int c = 0; c < KB_COLS; c++) begin
      if (col_cnt == 4'(c)) begin
        for (int r = 0; r < KB_ROWS; r++) begin
          cur_col[r] = key_q[r][c];
        end
      end
    end
  end

  assign ca2_d = |cur_col[KB_ROWS-1:1];

  always_ff @(posedge clk2MHz or negedge nRESET) begin
    if (!nRESET) begin
      key_q <= '0;
      ca2_q <= 1'b0;
    end else begin
      key_q <= key_d;
      ca2_q <= ca2_d;
    end
  end

  assign pa_row = PA_OUT[6:4];
  assign CA2    = ca2_q;

`ifdef KB_DIPSWITCH_EN
  logic [2:0] link_idx;

  assign link_idx = 3'(4'd9 - col_cnt);

  // Links are active-low: a fitted link (0) reads back as a pressed key.
  always_comb begin
    if (kb_is_link(pa_row, col_cnt)) begin
      PA7 = ~DIP_LINKS[link_idx];
    end else begin
      PA7 = cur_col[pa_row];
    end
  end
`else
  logic dip_unused;

  assign dip_unused = ^DIP_LINKS;
  assign PA7        = cur_col[pa_row];
`endif

endmodule
